// File: rtl/tick_period_monitor.sv
// -----------------------------------------------------------------------------
// tick_period_monitor
//
// Receive-side rate checker for a single-cycle tick strobe. It measures the
// number of i_clk cycles between rising edges of i_tick and compares each
// measurement against EXPECTED_PERIOD +/- TOLERANCE. After LOCK_COUNT
// consecutive good periods it reports lock. It also flags bad periods and
// ticks that stop arriving altogether.
//
// Parameters:
//   CNT_WIDTH       width of the interval counter and o_period
//   EXPECTED_PERIOD nominal tick period in i_clk cycles
//   TOLERANCE       allowed absolute deviation from EXPECTED_PERIOD
//   LOCK_COUNT      consecutive good periods needed for o_locked (>= 1)
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous reset, active-high
//   i_tick         tick strobe (rising edge counts, level ignored)
//   o_period       last measured period in cycles
//   o_period_valid one-cycle pulse when o_period updates
//   o_locked       high while the tick rate is within tolerance
//   o_error        one-cycle pulse on an out-of-tolerance period
//   o_timeout      one-cycle pulse when the counter saturates with no edge
// -----------------------------------------------------------------------------
module tick_period_monitor #(
    parameter int CNT_WIDTH       = 16,
    parameter int EXPECTED_PERIOD = 8,
    parameter int TOLERANCE       = 0,
    parameter int LOCK_COUNT      = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_tick,
    output logic [CNT_WIDTH-1:0] o_period,
    output logic                 o_period_valid,
    output logic                 o_locked,
    output logic                 o_error,
    output logic                 o_timeout
);

    localparam int                 MW       = $clog2(LOCK_COUNT + 1);
    localparam int                 CW1      = CNT_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CW1-1:0]       EXP_W    = CW1'(EXPECTED_PERIOD);
    localparam logic [CW1-1:0]       TOL_W    = CW1'(TOLERANCE);
    localparam logic [MW-1:0]        LOCK_M   = MW'(LOCK_COUNT);
    localparam logic [MW-1:0]        M_ZERO   = {MW{1'b0}};
    localparam logic [MW-1:0]        M_ONE    = MW'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  tick_q;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [MW-1:0]         match_q, match_d;
    logic [CNT_WIDTH-1:0]  period_q, period_d;
    logic                  valid_q, valid_d;
    logic                  locked_q, locked_d;
    logic                  error_q, error_d;
    logic                  timeout_q, timeout_d;

    logic                  edge_s;
    logic [CW1-1:0]        cnt_ext_s;
    logic [CW1-1:0]        diff_s;
    logic                  match_s;
    logic [MW-1:0]         match_inc_s;

    assign edge_s    = i_tick & ~tick_q;
    assign cnt_ext_s = {1'b0, cnt_q};

    // Absolute deviation of the current count from nominal, one bit wider so nothing wraps.
    always_comb begin
        if (cnt_ext_s >= EXP_W) begin
            diff_s = cnt_ext_s - EXP_W;
        end else begin
            diff_s = EXP_W - cnt_ext_s;
        end
        match_s = (diff_s <= TOL_W);
    end

    // Good-period streak, saturating at LOCK_COUNT.
    always_comb begin
        if (match_q >= LOCK_M) begin
            match_inc_s = LOCK_M;
        end else begin
            match_inc_s = match_q + M_ONE;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        match_d   = match_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        timeout_d = 1'b0;
        locked_d  = locked_q;

        case (state_q)
            ST_IDLE: begin
                // First edge only starts timing; no measurement yet.
                if (edge_s) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_MEASURE, ST_LOCKED: begin
                if (edge_s) begin
                    // Edge wins over saturation: a count of CNT_MAX is a real measurement.
                    cnt_d    = CNT_ONE;
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    if (match_s) begin
                        match_d = match_inc_s;
                        if (match_inc_s == LOCK_M) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end else begin
                            state_d  = state_q;
                        end
                    end else begin
                        match_d  = M_ZERO;
                        error_d  = 1'b1;
                        locked_d = 1'b0;
                        state_d  = ST_MEASURE;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    match_d   = M_ZERO;
                    cnt_d     = CNT_ZERO;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = CNT_ZERO;
                match_d  = M_ZERO;
                locked_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            tick_q    <= 1'b0;
            cnt_q     <= CNT_ZERO;
            match_q   <= M_ZERO;
            period_q  <= CNT_ZERO;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= i_tick;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_period       = period_q;
    assign o_period_valid = valid_q;
    assign o_locked       = locked_q;
    assign o_error        = error_q;
    assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_tick_period_monitor.sv
// -----------------------------------------------------------------------------
// tb_tick_period_monitor
//
// Drives one shared tick/reset stream into three monitor instances:
//   u_def : defaults
//   u_tol : TOLERANCE = 1
//   u_cw4 : CNT_WIDTH = 4 (saturates at 15)
// A timestamp-based reference model computes the expected outputs of each.
// -----------------------------------------------------------------------------
module tb_tick_period_monitor;

    localparam int EXPP  = 8;
    localparam int LOCKN = 4;

    logic        clk;
    logic        rst;
    logic        tick;

    logic [15:0] d_period;
    logic        d_valid, d_locked, d_error, d_timeout;
    logic [15:0] t_period;
    logic        t_valid, t_locked, t_error, t_timeout;
    logic [3:0]  c_period;
    logic        c_valid, c_locked, c_error, c_timeout;

    int checks   = 0;
    int failures = 0;

    tick_period_monitor u_def (
        .i_clk(clk), .i_rst(rst), .i_tick(tick),
        .o_period(d_period), .o_period_valid(d_valid), .o_locked(d_locked),
        .o_error(d_error), .o_timeout(d_timeout)
    );

    tick_period_monitor #(.TOLERANCE(1)) u_tol (
        .i_clk(clk), .i_rst(rst), .i_tick(tick),
        .o_period(t_period), .o_period_valid(t_valid), .o_locked(t_locked),
        .o_error(t_error), .o_timeout(t_timeout)
    );

    tick_period_monitor #(.CNT_WIDTH(4)) u_cw4 (
        .i_clk(clk), .i_rst(rst), .i_tick(tick),
        .o_period(c_period), .o_period_valid(c_valid), .o_locked(c_locked),
        .o_error(c_error), .o_timeout(c_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All observed outputs packed for whole-state comparison.
    logic [47:0] obs_all;
    assign obs_all = {d_period, d_valid, d_locked, d_error, d_timeout,
                      t_period, t_valid, t_locked, t_error, t_timeout,
                      c_period, c_valid, c_locked, c_error, c_timeout};

    // ---------------- reference model (timestamps, not counters) -------------
    int          p_tol [3] = '{0, 1, 0};
    int          p_max [3] = '{65535, 65535, 15};
    logic [15:0] m_period [3];
    logic        m_valid  [3];
    logic        m_locked [3];
    logic        m_err    [3];
    logic        m_to     [3];
    bit          armed    [3];
    int          last_edge[3];
    int          streak   [3];
    logic        m_prev;
    int          cyc = 0;

    task automatic model_step();
        bit e;
        int el;
        int diff;
        e = tick && !m_prev;
        if (rst) begin
            m_prev = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_period[i] = 16'd0; m_valid[i] = 1'b0; m_locked[i] = 1'b0;
                m_err[i] = 1'b0; m_to[i] = 1'b0; armed[i] = 1'b0;
                last_edge[i] = 0; streak[i] = 0;
            end
        end else begin
            m_prev = tick;
            for (int i = 0; i < 3; i++) begin
                m_valid[i] = 1'b0; m_err[i] = 1'b0; m_to[i] = 1'b0;
                if (armed[i]) begin
                    el = cyc - last_edge[i];
                    if (e) begin
                        m_period[i]  = 16'(el);
                        m_valid[i]   = 1'b1;
                        last_edge[i] = cyc;
                        diff = (el > EXPP) ? el - EXPP : EXPP - el;
                        if (diff <= p_tol[i]) begin
                            if (streak[i] < LOCKN) streak[i]++;
                            if (streak[i] >= LOCKN) m_locked[i] = 1'b1;
                        end else begin
                            streak[i] = 0; m_err[i] = 1'b1; m_locked[i] = 1'b0;
                        end
                    end else if (el == p_max[i]) begin
                        m_to[i] = 1'b1; armed[i] = 1'b0;
                        streak[i] = 0; m_locked[i] = 1'b0;
                    end
                end else if (e) begin
                    armed[i] = 1'b1;
                    last_edge[i] = cyc;
                end
            end
        end
        cyc++;
    endtask

    function automatic logic [47:0] exp_vec();
        logic [15:0] p2;
        p2 = m_period[2];
        return {m_period[0], m_valid[0], m_locked[0], m_err[0], m_to[0],
                m_period[1], m_valid[1], m_locked[1], m_err[1], m_to[1],
                p2[3:0],     m_valid[2], m_locked[2], m_err[2], m_to[2]};
    endfunction

    // One clock: inputs already set; model follows the edge; return on negedge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // ---------------- scenarios ---------------------------------------------
    task automatic test_reset();
        rst = 1'b1; tick = 1'b0;
        step(); step();
        checks++;
        if (obs_all !== 48'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs_all, 48'h0);
        end
        rst = 1'b0;
    endtask

    task automatic test_lock_in();
        int nv = 0;
        for (int e = 0; e < 6; e++) begin
            for (int c = 0; c < 8; c++) begin
                tick = (c == 0);
                step();
                checks++;
                if (obs_all !== exp_vec()) begin
                    failures++;
                    $display("FAIL lock_in_model cyc=%0d got=%h exp=%h", cyc, obs_all, exp_vec());
                end
                if (d_valid === 1'b1) begin
                    nv++;
                    checks++;
                    if (d_period !== 16'd8 || d_locked !== (nv >= 4) || d_error !== 1'b0) begin
                        failures++;
                        $display("FAIL lock_in_pulse n=%0d got period=%0d locked=%b err=%b exp period=8 locked=%b err=0",
                                 nv, d_period, d_locked, d_error, (nv >= 4));
                    end
                end
            end
        end
        checks++;
        if (nv != 5) begin
            failures++;
            $display("FAIL lock_in_count got=%0d exp=5", nv);
        end
    endtask

    task automatic test_loss_of_lock();
        int lens[6] = '{9, 8, 8, 8, 8, 8};
        int nerr = 0;
        for (int b = 0; b < 6; b++) begin
            for (int c = 0; c < lens[b]; c++) begin
                tick = (c == 0);
                step();
                checks++;
                if (obs_all !== exp_vec()) begin
                    failures++;
                    $display("FAIL loss_model cyc=%0d got=%h exp=%h", cyc, obs_all, exp_vec());
                end
                if (d_error === 1'b1) begin
                    nerr++;
                    checks++;
                    if (d_period !== 16'd9 || d_locked !== 1'b0 || t_error !== 1'b0) begin
                        failures++;
                        $display("FAIL loss_error got period=%0d locked=%b tol_err=%b exp 9/0/0",
                                 d_period, d_locked, t_error);
                    end
                end
            end
        end
        checks++;
        if (nerr != 1 || d_locked !== 1'b1) begin
            failures++;
            $display("FAIL loss_relock got errs=%0d locked=%b exp errs=1 locked=1", nerr, d_locked);
        end
    endtask

    task automatic test_tolerance();
        int lens[6] = '{7, 9, 8, 7, 10, 1};
        int nv = 0;
        rst = 1'b1; tick = 1'b0; step(); rst = 1'b0;
        for (int b = 0; b < 6; b++) begin
            for (int c = 0; c < lens[b]; c++) begin
                tick = (c == 0);
                step();
                checks++;
                if (obs_all !== exp_vec()) begin
                    failures++;
                    $display("FAIL tol_model cyc=%0d got=%h exp=%h", cyc, obs_all, exp_vec());
                end
                if (t_valid === 1'b1) begin
                    nv++;
                    checks++;
                    if (t_error !== (nv == 5) || t_locked !== (nv == 4)) begin
                        failures++;
                        $display("FAIL tol_pulse n=%0d got err=%b locked=%b exp err=%b locked=%b",
                                 nv, t_error, t_locked, (nv == 5), (nv == 4));
                    end
                end
            end
        end
        checks++;
        if (nv != 5) begin
            failures++;
            $display("FAIL tol_count got=%0d exp=5", nv);
        end
    endtask

    task automatic test_timeout();
        int nto = 0;
        int nv  = 0;
        rst = 1'b1; tick = 1'b0; step(); rst = 1'b0;
        // one edge then silence: counter of u_cw4 saturates at 15
        for (int c = 0; c < 21; c++) begin
            tick = (c == 0);
            step();
            checks++;
            if (obs_all !== exp_vec()) begin
                failures++;
                $display("FAIL timeout_model cyc=%0d got=%h exp=%h", cyc, obs_all, exp_vec());
            end
            if (c_timeout === 1'b1) nto++;
        end
        checks++;
        if (nto != 1 || c_locked !== 1'b0 || d_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse got count=%0d locked=%b def_to=%b exp 1/0/0", nto, c_locked, d_timeout);
        end
        // restart: first edge only arms, second measures 8
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < 8; c++) begin
                tick = (c == 0);
                step();
                checks++;
                if (obs_all !== exp_vec()) begin
                    failures++;
                    $display("FAIL timeout_restart_model cyc=%0d got=%h exp=%h", cyc, obs_all, exp_vec());
                end
                if (c_valid === 1'b1) nv++;
            end
        end
        // edge exactly at saturation: measured as 15, no timeout
        for (int c = 0; c < 15; c++) begin
            tick = (c == 0);
            step();
            if (c_valid === 1'b1) nv++;
        end
        tick = 1'b1;
        step();
        if (c_valid === 1'b1) nv++;
        checks++;
        if (nv != 3 || c_period !== 4'd15 || c_timeout !== 1'b0 || c_error !== 1'b1) begin
            failures++;
            $display("FAIL timeout_edge_wins got valids=%0d period=%0d to=%b err=%b exp 3/15/0/1",
                     nv, c_period, c_timeout, c_error);
        end
        tick = 1'b0;
        step();
    endtask

    task automatic test_held_tick();
        int nv = 0;
        rst = 1'b1; tick = 1'b0; step(); rst = 1'b0;
        for (int e = 0; e < 6; e++) begin
            for (int c = 0; c < 8; c++) begin
                tick = (c < 5);
                step();
                checks++;
                if (obs_all !== exp_vec()) begin
                    failures++;
                    $display("FAIL held_model cyc=%0d got=%h exp=%h", cyc, obs_all, exp_vec());
                end
                if (d_valid === 1'b1) begin
                    nv++;
                    checks++;
                    if (d_period !== 16'd8 || d_locked !== (nv >= 4)) begin
                        failures++;
                        $display("FAIL held_pulse n=%0d got period=%0d locked=%b exp 8/%b",
                                 nv, d_period, d_locked, (nv >= 4));
                    end
                end
            end
        end
        checks++;
        if (nv != 5) begin
            failures++;
            $display("FAIL held_count got=%0d exp=5", nv);
        end
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        int first_valid_block = -1;
        // a few cycles into a period while locked
        tick = 1'b1; step(); tick = 1'b0; step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        checks++;
        if (obs_all !== 48'h0) begin
            failures++;
            $display("FAIL reset_mid_state got=%h exp=%h", obs_all, 48'h0);
        end
        for (int b = 0; b < 3; b++) begin
            for (int c = 0; c < 8; c++) begin
                tick = (c == 0);
                step();
                checks++;
                if (obs_all !== exp_vec()) begin
                    failures++;
                    $display("FAIL reset_mid_model cyc=%0d got=%h exp=%h", cyc, obs_all, exp_vec());
                end
                if (d_valid === 1'b1) begin
                    nv++;
                    if (first_valid_block < 0) first_valid_block = b;
                end
            end
        end
        checks++;
        if (first_valid_block != 1 || nv != 2 || d_period !== 16'd8) begin
            failures++;
            $display("FAIL reset_mid_resume got block=%0d valids=%0d period=%0d exp 1/2/8",
                     first_valid_block, nv, d_period);
        end
    endtask

    task automatic test_random();
        int len;
        int w;
        for (int b = 0; b < 250; b++) begin
            if ($urandom_range(0, 9) == 0) begin
                len = int'($urandom_range(14, 24));
            end else begin
                len = int'($urandom_range(2, 11));
            end
            w = int'($urandom_range(1, len - 1));
            for (int c = 0; c < len; c++) begin
                tick = (c < w);
                rst  = ($urandom_range(0, 299) == 0);
                step();
                checks++;
                if (obs_all !== exp_vec()) begin
                    failures++;
                    $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, obs_all, exp_vec());
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        tick = 1'b0;
        m_prev = 1'b0;
        @(negedge clk);
        test_reset();
        test_lock_in();
        test_loss_of_lock();
        test_tolerance();
        test_timeout();
        test_held_tick();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_period_monitor.md
Name: tick_period_monitor

Overview:
- Receive-side checker for the single-cycle tick strobe produced by the clock divider.
- Measures the interval between tick rising edges in i_clk cycles and compares it to an expected period within a tolerance.
- Declares lock after N consecutive good periods, and flags mismatches and missing ticks.
- Sits beside any tick-driven logic, such as the Gray counter, as a rate sanity monitor and bench/debug aid.

Parameters:
- CNT_WIDTH, 16, width of the interval counter and o_period.
- EXPECTED_PERIOD, 8, nominal tick period in i_clk cycles (2..2^CNT_WIDTH-2).
- TOLERANCE, 0, allowed absolute deviation from EXPECTED_PERIOD in cycles.
- LOCK_COUNT, 4, consecutive in-tolerance periods required to assert o_locked (>=1).

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  synchronous reset, active-high.
- i_tick  input  1  tick strobe, same clock domain. Only the rising edge counts.
- o_period  output  CNT_WIDTH  last measured period in cycles.
- o_period_valid  output  1  one-cycle pulse when o_period updates.
- o_locked  output  1  level, high while the tick rate is within tolerance.
- o_error  output  1  one-cycle pulse on an out-of-tolerance period.
- o_timeout  output  1  one-cycle pulse when the interval counter saturates without an edge.

Behaviour:
- Reset (sync, active-high, sampled on posedge i_clk):
  - tick_q=0, interval cnt=0, match cnt=0, state=IDLE.
  - All outputs 0, including o_period.
  - Reset mid-measurement discards the partial interval. The first edge after reset only starts timing.
- Edge detect: edge = i_tick & ~tick_q, with tick_q registered each cycle. If i_tick is held high for k cycles, it counts as one edge.
- Interval counter:
  - Loads 1 in the cycle after an edge. Otherwise increments by 1 per cycle while state != IDLE.
  - Measured period = cnt value at the edge cycle. Ticks every 8 cycles therefore give period = 8.
- Outputs are registered. o_period, o_period_valid, o_error and o_locked update on the clock edge ending the edge cycle, one cycle after i_tick rises.
- Match test: |period - EXPECTED_PERIOD| <= TOLERANCE, computed in CNT_WIDTH+1 bits with no wrap.
- State IDLE:
  - Counter held at 0, no valid pulses.
  - edge -> MEASURE, counter starts.
- State MEASURE:
  - On edge: o_period <= cnt, o_period_valid pulses.
  - Match: match cnt++. When it reaches LOCK_COUNT -> LOCKED, o_locked <= 1.
  - No match: match cnt <= 0, o_error pulses.
- State LOCKED:
  - On edge: o_period <= cnt, o_period_valid pulses.
  - Match: stay in LOCKED.
  - No match: o_error pulses, o_locked <= 0, match cnt <= 0, -> MEASURE. The failing edge also starts the next interval.
- Timeout:
  - Applies in MEASURE or LOCKED when cnt reaches 2^CNT_WIDTH-1 with no edge.
  - o_timeout pulses, o_locked <= 0, match cnt <= 0, cnt <= 0, -> IDLE. o_period is unchanged.
  - If an edge and saturation occur in the same cycle, the edge wins: a normal measurement with period = max value, no timeout.
- Match counter saturates at LOCK_COUNT. No wrap.
- o_period holds its last value until the next measurement or reset.

Test Plan:
- Lock-in: defaults, i_tick one-cycle pulse every 8 cycles. First edge gives no valid pulse. Each later edge gives o_period_valid with o_period=8. o_locked rises with the 4th valid pulse. o_error stays 0 throughout.
- Loss of lock: after lock, one interval of 9 cycles (TOLERANCE=0) -> o_error pulse, o_period=9, o_locked falls in the same cycle. Four further 8-cycle periods re-lock.
- Tolerance: TOLERANCE=1, periods 7,9,8,7 -> no o_error, lock after the 4th. A period of 10 -> o_error pulse and lock drop.
- Timeout: CNT_WIDTH=4, one edge, then i_tick low -> o_timeout pulse once cnt hits 15, state IDLE, o_locked=0. The next edge produces no valid pulse; the one after measures normally.
- Held tick: i_tick held high 5 cycles every 8 -> treated as one edge per period, o_period=8, lock after 4 periods.
- Reset mid-operation: assert i_rst for 1 cycle while locked and mid-interval -> all outputs 0 next cycle. Ticks resume at period 8 -> first valid pulse on the 2nd edge after reset, with o_period=8.
